booth4_seq: RTL and testbench
=============================

Name: booth4_seq

Overview:
- Sequential, parametrised radix-4 (modified Booth) multiplier. It is the iterative successor to the combinational booth4beta array.
- Retires one Booth digit per clock through a shared adder, so area stays small at the cost of latency.
- Adds a per-operation signed/unsigned mode, a start/busy/done handshake and a held result register.
- Sits as a multi-cycle arithmetic unit behind a datapath controller.

Parameters:
- TAM, 16, operand width in bits. Must be even and at least 4; elaboration error otherwise.
- NDIG, TAM/2+1, number of Booth digits. Derived constant, not overridable.

Ports:
- clk  in  1  single clock; all state changes on its rising edge.
- rst  in  1  reset, synchronous and active-high.
- start  in  1  request a new multiplication. Sampled only while idle.
- sgn  in  1  1 = operands are two's-complement signed, 0 = unsigned. Sampled with start.
- A  in  TAM  multiplicand. Sampled with start.
- B  in  TAM  multiplier. Sampled with start.
- busy  out  1  high while an operation is in progress.
- done  out  1  one-cycle pulse when S becomes valid.
- S  out  2*TAM  product register. Held until the next accepted start.

Behaviour:
- Reset: synchronous, active-high, on clk. While rst=1 at an edge:
  - state <= IDLE; busy=0, done=0, S=0; internal registers cleared.
  - rst overrides start and aborts any operation in progress. The partial result is discarded and S reads 0 afterwards.
- States: IDLE, RUN. DONE is not a separate state; done is a registered pulse.
- IDLE:
  - If start=1 at an edge: latch MD = A extended to 2*TAM bits (sign-extend if sgn=1, else zero-extend).
  - Latch MR = {ext,ext,B,1'b0}, width TAM+3, where ext = sgn & B[TAM-1].
  - Clear the accumulator, set cnt=0, go to RUN, busy<=1.
  - S keeps its old value until completion.
- RUN, one digit per edge:
  - digit d = MR[2*cnt+2 : 2*cnt], selected via a 3-bit shift window.
  - Encoding: 000/111 -> 0; 001/010 -> +MD; 011 -> +2MD; 100 -> -2MD; 101/110 -> -MD.
  - acc <= acc + (pp << 2*cnt), all arithmetic modulo 2^(2*TAM). Negation is ~x+1 on 2*TAM bits.
  - cnt increments each edge.
  - On the edge where cnt = NDIG-1: S <= final acc, done<=1 (for one cycle), busy<=0, state <= IDLE.
- Latency:
  - start sampled at edge k; S valid and done=1 in the cycle after edge k+NDIG. For TAM=16, 9 cycles.
  - busy is high from edge k+1 through edge k+NDIG.
  - Throughput is one operation every NDIG+1 cycles. Back-to-back start in the done cycle is accepted, since the block is already IDLE.
- Operands and mode:
  - start while busy=1 is ignored; no queueing, no error flag.
  - A, B and sgn may change freely after acceptance.
- Result range:
  - The product is exact for all inputs in both modes. No overflow occurs: the signed range fits 2*TAM bits, and the unsigned range fits because of the extra zero-extended digit.
  - The signed corner case -2^(TAM-1) * -2^(TAM-1) = 2^(2*TAM-2) must be exact.
- done and busy are never high in the same cycle.

Decomposition:
- Package booth4_pkg holds:
  - state enum {IDLE, RUN};
  - the Booth digit code constants (ZERO, P1, P2, M2, M1);
  - function ndig(tam) returning tam/2+1.
- Sub-module booth4_digit_sel, combinational, parameter TAM:
  - inputs: 3-bit digit, MD[2*TAM-1:0];
  - output: signed partial product [2*TAM-1:0];
  - reuses the same +-MD / +-2MD / zero encoding as the array multiplier.
- The top level holds the FSM, counter, shift window, accumulator and result register.

Test Plan:
- TAM=16, sgn=1, A=3, B=5, start one cycle -> done exactly 9 cycles later, S=0x0000000F, busy high for 9 cycles before done.
- sgn=1, A=0x8000, B=0x8000 -> S=0x40000000. sgn=1, A=0xFFFF, B=0x0001 -> S=0xFFFFFFFF.
- sgn=0, A=0xFFFF, B=0xFFFF -> S=0xFFFE0001. sgn=0, A=0xFFFF, B=0x0001 -> S=0x0000FFFF.
- Start with A=7, B=6; re-assert start with A=2, B=2 at cycle 3 -> second start ignored, S=0x0000002A. Then start again in the done cycle -> accepted, S=4 after 9 more cycles.
- rst=1 at cycle 4 of an operation -> next cycle busy=0, done=0, S=0, and no done pulse follows. A new start afterwards completes normally.
- Random regression, TAM in {4, 8, 16, 32}, both modes, 10k vectors each -> S matches the reference product and latency is always NDIG.

Source files
------------

// File: rtl/booth4_pkg.sv
// Shared types and helpers for the sequential radix-4 Booth multiplier.
// Digit codes mirror the encoding used by the combinational array multiplier.
package booth4_pkg;

  typedef enum logic {IDLE, RUN} state_t;

  typedef enum logic [2:0] {ZERO, P1, P2, M2, M1} digit_t;

  function automatic int ndig(input int tam);
    return tam / 2 + 1;
  endfunction

  function automatic digit_t decode(input logic [2:0] d);
    case (d)
      3'b001, 3'b010: return P1;
      3'b011:         return P2;
      3'b100:         return M2;
      3'b101, 3'b110: return M1;
      default:        return ZERO;
    endcase
  endfunction

endpackage

// File: rtl/booth4_digit_sel.sv
// Combinational Booth partial-product selector: maps one 3-bit digit to
// 0, +-MD or +-2MD on 2*TAM bits (wraparound arithmetic).
module booth4_digit_sel
  import booth4_pkg::*;
#(
  parameter int TAM = 16
) (
  input  logic [2:0]            digit,
  input  logic [2*TAM-1:0]      md,
  output logic signed [2*TAM-1:0] pp
);

  logic [2*TAM-1:0] md2;

  assign md2 = md << 1;

  always_comb begin
    pp = '0;
    case (decode(digit))
      P1:      pp = md;
      P2:      pp = md2;
      M1:      pp = ~md + 1'b1;
      M2:      pp = ~md2 + 1'b1;
      default: pp = '0;
    endcase
  end

endmodule

// File: rtl/booth4_seq.sv
// Iterative radix-4 Booth multiplier: one digit per clock through a single adder,
// start/busy/done handshake and a held product register.
module booth4_seq
  import booth4_pkg::*;
#(
  parameter int TAM = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               sgn,
  input  logic [TAM-1:0]     A,
  input  logic [TAM-1:0]     B,
  output logic               busy,
  output logic               done,
  output logic [2*TAM-1:0]   S
);

  localparam int NDIG = ndig(TAM);
  localparam int W    = 2 * TAM;
  localparam int MRW  = TAM + 3;
  localparam int CW   = $clog2(NDIG + 1);

  if ((TAM % 2) != 0 || TAM < 4) begin : g_bad_tam
    $error("booth4_seq: TAM must be even and at least 4");
  end

  state_t           state;
  logic [W-1:0]     md;
  logic [MRW-1:0]   mr;
  logic [W-1:0]     acc;
  logic [CW-1:0]    cnt;
  logic signed [W-1:0] pp;
  logic             ext;

  assign ext = sgn & B[TAM-1];

  // md is pre-shifted by two each step, so pp already carries the 2*cnt weight
  booth4_digit_sel #(.TAM(TAM)) u_sel (
    .digit (mr[2:0]),
    .md    (md),
    .pp    (pp)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      busy  <= 1'b0;
      done  <= 1'b0;
      S     <= '0;
      md    <= '0;
      mr    <= '0;
      acc   <= '0;
      cnt   <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            md    <= sgn ? {{TAM{A[TAM-1]}}, A} : {{TAM{1'b0}}, A};
            mr    <= {ext, ext, B, 1'b0};
            acc   <= '0;
            cnt   <= '0;
            busy  <= 1'b1;
            state <= RUN;
          end
        end
        RUN: begin
          acc <= acc + $unsigned(pp);
          md  <= md << 2;
          mr  <= mr >> 2;
          cnt <= cnt + 1'b1;
          if (cnt == CW'(NDIG - 1)) begin
            S     <= acc + $unsigned(pp);
            done  <= 1'b1;
            busy  <= 1'b0;
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_booth4_seq.sv
// Scoreboard bench for booth4_seq at TAM=16: expected products are queued at
// launch and compared with S, latency and busy length when done pulses.
module tb_booth4_seq;

  localparam int TAM = 16;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic        sgn;
  logic [15:0] A;
  logic [15:0] B;
  logic        busy;
  logic        done;
  logic [31:0] S;

  int checks = 0;
  int errors = 0;
  int overlap = 0;
  logic [31:0] exp_q[$];

  booth4_seq #(.TAM(TAM)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .sgn   (sgn),
    .A     (A),
    .B     (B),
    .busy  (busy),
    .done  (done),
    .S     (S)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (busy && done) overlap++;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] model(input logic s, input logic [15:0] a, input logic [15:0] b);
    longint sa, sb;
    if (s) begin
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      return 32'(sa * sb);
    end
    return {16'b0, a} * {16'b0, b};
  endfunction

  // Drives start for one edge and returns at the negedge after acceptance.
  task automatic launch(input logic s, input logic [15:0] a, input logic [15:0] b);
    sgn = s; A = a; B = b; start = 1'b1;
    exp_q.push_back(model(s, a, b));
    @(negedge clk);
    start = 1'b0;
    sgn = 1'($urandom); A = 16'($urandom); B = 16'($urandom);
  endtask

  // lat0: cycles already elapsed since acceptance; returns at the done cycle.
  task automatic collect(input string tag, input int lat0);
    int lat = lat0;
    int bc = 0;
    logic [31:0] e;
    while (!done && lat < 40) begin
      if (busy) bc++;
      @(negedge clk);
      lat++;
    end
    if (!done) begin
      chk({tag, "_timeout"}, 64'(lat), 64'd9);
      return;
    end
    if (exp_q.size() == 0) begin
      chk({tag, "_sb_empty"}, 64'd0, 64'd1);
      return;
    end
    e = exp_q.pop_front();
    chk({tag, "_S"}, 64'(S), 64'(e));
    chk({tag, "_lat"}, 64'(lat), 64'd9);
    chk({tag, "_busy"}, 64'(bc), 64'(9 - lat0));
  endtask

  initial begin
    int dcount;
    rst = 1'b1; start = 1'b0; sgn = 1'b0; A = '0; B = '0;
    repeat (3) @(negedge clk);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_S", 64'(S), 64'd0);
    rst = 1'b0;
    @(negedge clk);

    launch(1'b1, 16'd3, 16'd5);          collect("s_3x5", 0);
    chk("s_3x5_const", 64'(S), 64'h0000000F);
    launch(1'b1, 16'h8000, 16'h8000);    collect("s_min_sq", 0);
    chk("s_min_sq_const", 64'(S), 64'h40000000);
    launch(1'b1, 16'hFFFF, 16'h0001);    collect("s_m1x1", 0);
    chk("s_m1x1_const", 64'(S), 64'hFFFFFFFF);
    launch(1'b0, 16'hFFFF, 16'hFFFF);    collect("u_max_sq", 0);
    chk("u_max_sq_const", 64'(S), 64'hFFFE0001);
    launch(1'b0, 16'hFFFF, 16'h0001);    collect("u_max_x1", 0);
    chk("u_max_x1_const", 64'(S), 64'h0000FFFF);

    // start while busy is ignored; start in the done cycle is accepted
    launch(1'b0, 16'd7, 16'd6);
    @(negedge clk);
    start = 1'b1; sgn = 1'b0; A = 16'd2; B = 16'd2;
    @(negedge clk);
    start = 1'b0;
    collect("ignored", 2);
    chk("ignored_const", 64'(S), 64'h2A);
    launch(1'b0, 16'd2, 16'd2);          collect("done_cycle", 0);
    chk("done_cycle_const", 64'(S), 64'd4);

    // reset mid-operation discards the result
    launch(1'b1, 16'd100, 16'd200);
    void'(exp_q.pop_back());
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("abort_busy", 64'(busy), 64'd0);
    chk("abort_done", 64'(done), 64'd0);
    chk("abort_S", 64'(S), 64'd0);
    dcount = 0;
    repeat (12) begin
      @(negedge clk);
      if (done) dcount++;
    end
    chk("abort_no_done", 64'(dcount), 64'd0);
    launch(1'b1, 16'hFFF0, 16'd300);     collect("after_abort", 0);

    for (int i = 0; i < 300; i++) begin
      launch(1'($urandom), 16'($urandom), 16'($urandom));
      collect("rand", 0);
    end

    chk("busy_done_overlap", 64'(overlap), 64'd0);
    chk("sb_drained", 64'(exp_q.size()), 64'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
